// File: rtl/wb_flush_gen_pkg.sv
// ============================================================================
// Module : wb_flush_gen_pkg
// Brief  : Shared definitions for the writeback flush protocol: cause codes,
//          flush FSM state encodings and the cause priority decoder, so the
//          hazard unit decodes causes exactly as the generator does.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_flush_gen_pkg;

    // Flush cause codes (3-bit native width)
    localparam logic [2:0] CAUSE_NONE      = 3'd0;
    localparam logic [2:0] CAUSE_EXCP      = 3'd1;
    localparam logic [2:0] CAUSE_ERTN      = 3'd2;
    localparam logic [2:0] CAUSE_MISPRED   = 3'd3;
    localparam logic [2:0] CAUSE_REFETCH   = 3'd4;
    localparam logic [2:0] CAUSE_IBAR      = 3'd5;
    localparam logic [2:0] CAUSE_IDLE_WAKE = 3'd6;

    // Flush FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    // Cause priority: excp > ertn > mispred > ibar > idle > refetch.
    // Lower-priority flags are dropped when a higher one is present.
    function automatic logic [2:0] pick_cause(
        input logic excp,
        input logic ertn,
        input logic mispred,
        input logic ibar,
        input logic idle,
        input logic refetch
    );
        if (excp)         return CAUSE_EXCP;
        else if (ertn)    return CAUSE_ERTN;
        else if (mispred) return CAUSE_MISPRED;
        else if (ibar)    return CAUSE_IBAR;
        else if (idle)    return CAUSE_IDLE_WAKE;
        else if (refetch) return CAUSE_REFETCH;
        else              return CAUSE_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_flush_gen_perf_cnt.sv
// ============================================================================
// Module : wb_flush_gen_perf_cnt
// Brief  : Flush performance counters: total flushes and mispredict flushes.
//          Instantiated by wb_flush_gen only when WB_FLUSH_PERF_CNT_EN is set.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_flush_gen_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             mispred,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    // Count on the single FLUSH cycle; counters wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt   <= '0;
            mispred_cnt <= '0;
        end else if (flush) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
            if (mispred) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_flush_gen.sv
// ============================================================================
// Module : wb_flush_gen
// Brief  : Writeback-stage flush request generator. Decides when a retiring
//          instruction flushes the pipeline, produces redirect PC and cause,
//          and owns the ibar drain and idle wait-for-interrupt waits.
//          Optional macro WB_FLUSH_PERF_CNT_EN adds flush perf counters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_flush_gen
    import wb_flush_gen_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int CAUSE_W = 3,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_valid,
    output logic               wb_ready,
    input  logic [PC_W-1:0]    wb_pc,
    input  logic               wb_excp,
    input  logic               wb_ertn,
    input  logic               wb_br_mispred,
    input  logic [PC_W-1:0]    wb_br_target,
    input  logic               wb_refetch,
    input  logic               wb_ibar,
    input  logic               wb_idle,
    input  logic [PC_W-1:0]    csr_eentry,
    input  logic [PC_W-1:0]    csr_era,
    input  logic               intr_pending,
    input  logic               dcache_idle,
`ifdef WB_FLUSH_PERF_CNT_EN
    output logic [CNT_W-1:0]   perf_flush_cnt,
    output logic [CNT_W-1:0]   perf_mispred_cnt,
`endif
    output logic               flush_from_wb,
    output logic [PC_W-1:0]    redirect_pc,
    output logic [CAUSE_W-1:0] flush_cause
);

    logic [1:0]      state;
    logic [1:0]      next_state;
    logic            accept;
    logic [2:0]      sel_cause;
    logic [PC_W-1:0] sel_target;
    logic [PC_W-1:0] pc_plus4;
    logic [2:0]      pend_cause;
    logic [PC_W-1:0] pend_target;
    logic            enter_flush;
    logic [2:0]      flush_cause_src;
    logic [PC_W-1:0] flush_target_src;

    assign wb_ready = (state == ST_IDLE);
    assign accept   = wb_valid & wb_ready;
    // Sequential-next PC wraps modulo 2^PC_W
    assign pc_plus4 = wb_pc + PC_W'(4);

    assign sel_cause = pick_cause(wb_excp, wb_ertn, wb_br_mispred,
                                  wb_ibar, wb_idle, wb_refetch);

    // Restart target for the winning cause
    always_comb begin
        sel_target = pc_plus4;
        case (sel_cause)
            CAUSE_EXCP:    sel_target = csr_eentry;
            CAUSE_ERTN:    sel_target = csr_era;
            CAUSE_MISPRED: sel_target = wb_br_target;
            default:       sel_target = pc_plus4;
        endcase
    end

    // Next-state logic for the flush FSM
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (sel_cause)
                        CAUSE_NONE:      next_state = ST_IDLE;
                        CAUSE_IBAR:      next_state = ST_DRAIN;
                        CAUSE_IDLE_WAKE: next_state = ST_HALT;
                        default:         next_state = ST_FLUSH;
                    endcase
                end
            end
            ST_DRAIN: if (dcache_idle)  next_state = ST_FLUSH;
            ST_HALT:  if (intr_pending) next_state = ST_FLUSH;
            ST_FLUSH: next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    assign enter_flush = (next_state == ST_FLUSH);

    // Direct flushes take the live decode; waited flushes use the latched one
    assign flush_cause_src  = (state == ST_IDLE) ? sel_cause  : pend_cause;
    assign flush_target_src = (state == ST_IDLE) ? sel_target : pend_target;

    // FSM state register; async reset abandons any drain/halt wait
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Latch cause/target of an accepted flagged instruction for waited flushes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_cause  <= CAUSE_NONE;
            pend_target <= '0;
        end else if (accept && (sel_cause != CAUSE_NONE)) begin
            pend_cause  <= sel_cause;
            pend_target <= sel_target;
        end
    end

    // Registered flush outputs: pulse and cause only in FLUSH, PC holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_from_wb <= 1'b0;
            flush_cause   <= '0;
            redirect_pc   <= '0;
        end else begin
            flush_from_wb <= enter_flush;
            flush_cause   <= enter_flush ? CAUSE_W'(flush_cause_src) : '0;
            if (enter_flush) begin
                redirect_pc <= flush_target_src;
            end
        end
    end

`ifdef WB_FLUSH_PERF_CNT_EN
    wb_flush_gen_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush_from_wb),
        .mispred     (flush_cause == CAUSE_W'(CAUSE_MISPRED)),
        .flush_cnt   (perf_flush_cnt),
        .mispred_cnt (perf_mispred_cnt)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_flush_gen.sv
// ============================================================================
// Module : tb_wb_flush_gen
// Brief  : Self-checking bench for wb_flush_gen: directed scenarios plus
//          randomized instructions against a transaction-level model.
//          Honours WB_FLUSH_PERF_CNT_EN for the perf counter outputs.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_flush_gen;

    localparam int PC_W    = 32;
    localparam int CAUSE_W = 3;
    localparam int CNT_W   = 32;

    logic               clk;
    logic               rst;
    logic               wb_valid;
    logic               wb_ready;
    logic [PC_W-1:0]    wb_pc;
    logic               wb_excp;
    logic               wb_ertn;
    logic               wb_br_mispred;
    logic [PC_W-1:0]    wb_br_target;
    logic               wb_refetch;
    logic               wb_ibar;
    logic               wb_idle;
    logic [PC_W-1:0]    csr_eentry;
    logic [PC_W-1:0]    csr_era;
    logic               intr_pending;
    logic               dcache_idle;
    logic               flush_from_wb;
    logic [PC_W-1:0]    redirect_pc;
    logic [CAUSE_W-1:0] flush_cause;
`ifdef WB_FLUSH_PERF_CNT_EN
    logic [CNT_W-1:0]   perf_flush_cnt;
    logic [CNT_W-1:0]   perf_mispred_cnt;
`endif

    int checks;
    int errors;

    // Model state: last redirect PC and flush counts
    logic [PC_W-1:0] last_redirect;
    int              n_flush;
    int              n_mispred;

    wb_flush_gen #(
        .PC_W    (PC_W),
        .CAUSE_W (CAUSE_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .wb_valid         (wb_valid),
        .wb_ready         (wb_ready),
        .wb_pc            (wb_pc),
        .wb_excp          (wb_excp),
        .wb_ertn          (wb_ertn),
        .wb_br_mispred    (wb_br_mispred),
        .wb_br_target     (wb_br_target),
        .wb_refetch       (wb_refetch),
        .wb_ibar          (wb_ibar),
        .wb_idle          (wb_idle),
        .csr_eentry       (csr_eentry),
        .csr_era          (csr_era),
        .intr_pending     (intr_pending),
        .dcache_idle      (dcache_idle),
`ifdef WB_FLUSH_PERF_CNT_EN
        .perf_flush_cnt   (perf_flush_cnt),
        .perf_mispred_cnt (perf_mispred_cnt),
`endif
        .flush_from_wb    (flush_from_wb),
        .redirect_pc      (redirect_pc),
        .flush_cause      (flush_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample/drive 1 time unit after the active edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: flags in priority order; the first set flag names the cause.
    // f = {excp, ertn, mispred, ibar, idle, refetch}
    function automatic int model_cause(input logic [5:0] f);
        int prio_cause [6] = '{1, 2, 3, 5, 6, 4};
        for (int i = 0; i < 6; i++) begin
            if (f[5-i]) return prio_cause[i];
        end
        return 0;
    endfunction

    function automatic logic [31:0] model_target(input int cause, input logic [31:0] pc,
                                                 input logic [31:0] tgt, input logic [31:0] ee,
                                                 input logic [31:0] era);
        longint unsigned nxt;
        nxt = (longint'(pc) + 4) % (64'd1 << 32);
        case (cause)
            1:       return ee;
            2:       return era;
            3:       return tgt;
            default: return nxt[31:0];
        endcase
    endfunction

    // Present one instruction, accept it, then follow its expected timeline
    task automatic issue(input logic [5:0] f, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [31:0] ee, input logic [31:0] era, input int waitn);
        int          cause;
        logic [31:0] exp_pc;
        cause  = model_cause(f);
        exp_pc = model_target(cause, pc, tgt, ee, era);
        {wb_excp, wb_ertn, wb_br_mispred, wb_ibar, wb_idle, wb_refetch} = f;
        wb_pc        = pc;
        wb_br_target = tgt;
        csr_eentry   = ee;
        csr_era      = era;
        dcache_idle  = 1'b0;
        intr_pending = 1'b0;
        wb_valid     = 1'b1;
        check("ready_before_accept", 32'(wb_ready), 32'd1);
        step();
        wb_valid = 1'b0;
        {wb_excp, wb_ertn, wb_br_mispred, wb_ibar, wb_idle, wb_refetch} = 6'b0;
        if (cause == 0) begin
            check("noflag_flush", 32'(flush_from_wb), 32'd0);
            check("noflag_ready", 32'(wb_ready), 32'd1);
            check("noflag_cause", 32'(flush_cause), 32'd0);
            return;
        end
        if (cause == 5 || cause == 6) begin
            for (int i = 0; i < waitn; i++) begin
                check("wait_ready", 32'(wb_ready), 32'd0);
                check("wait_flush", 32'(flush_from_wb), 32'd0);
                step();
            end
            if (cause == 5) dcache_idle = 1'b1;
            else            intr_pending = 1'b1;
            check("wake_ready", 32'(wb_ready), 32'd0);
            check("wake_flush", 32'(flush_from_wb), 32'd0);
            step();
            dcache_idle  = 1'b0;
            intr_pending = 1'b0;
        end
        check("flush_pulse", 32'(flush_from_wb), 32'd1);
        check("flush_pc", redirect_pc, exp_pc);
        check("flush_cause", 32'(flush_cause), 32'(cause));
        check("flush_ready", 32'(wb_ready), 32'd0);
        last_redirect = exp_pc;
        n_flush++;
        if (cause == 3) n_mispred++;
        step();
        check("post_flush", 32'(flush_from_wb), 32'd0);
        check("post_cause", 32'(flush_cause), 32'd0);
        check("post_ready", 32'(wb_ready), 32'd1);
        check("post_pc_hold", redirect_pc, last_redirect);
    endtask

    initial begin
        logic [5:0]  f;
        logic [31:0] rpc;
        checks        = 0;
        errors        = 0;
        last_redirect = '0;
        n_flush       = 0;
        n_mispred     = 0;
        rst           = 1'b1;
        wb_valid      = 1'b0;
        wb_pc         = '0;
        {wb_excp, wb_ertn, wb_br_mispred, wb_ibar, wb_idle, wb_refetch} = 6'b0;
        wb_br_target  = '0;
        csr_eentry    = '0;
        csr_era       = '0;
        intr_pending  = 1'b0;
        dcache_idle   = 1'b0;
        step();
        step();
        check("rst_ready", 32'(wb_ready), 32'd1);
        check("rst_flush", 32'(flush_from_wb), 32'd0);
        check("rst_pc", redirect_pc, 32'd0);
        check("rst_cause", 32'(flush_cause), 32'd0);
        rst = 1'b0;
        step();

        // Directed scenarios
        issue(6'b001000, 32'h1c00_0000, 32'h1c00_0100, 32'h0, 32'h0, 0);            // mispredict
        issue(6'b110000, 32'h1c00_0010, 32'h0, 32'h1c00_8000, 32'h1c00_9000, 0);    // excp beats ertn
        issue(6'b000100, 32'h1c00_0200, 32'h0, 32'h0, 32'h0, 5);                    // ibar, 5-cycle drain
        issue(6'b000100, 32'h1c00_0220, 32'h0, 32'h0, 32'h0, 0);                    // ibar, already drained
        issue(6'b000010, 32'h1c00_0300, 32'h0, 32'h0, 32'h0, 20);                   // idle wakeup
        issue(6'b000001, 32'hffff_fffc, 32'h0, 32'h0, 32'h0, 0);                    // refetch PC wrap
        issue(6'b000000, 32'h1c00_0400, 32'h0, 32'h0, 32'h0, 0);                    // plain retire
        issue(6'b000111, 32'h1c00_0500, 32'h0, 32'h0, 32'h0, 1);                    // ibar beats idle/refetch

        // Reset while halted: wait abandoned, no flush afterwards
        wb_pc    = 32'h1c00_0600;
        wb_idle  = 1'b1;
        wb_valid = 1'b1;
        step();
        wb_valid = 1'b0;
        wb_idle  = 1'b0;
        step();
        step();
        check("halt_ready", 32'(wb_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("midrst_flush", 32'(flush_from_wb), 32'd0);
        check("midrst_ready", 32'(wb_ready), 32'd1);
        check("midrst_pc", redirect_pc, 32'd0);
        last_redirect = '0;
        n_flush       = 0;
        n_mispred     = 0;
        step();
        rst          = 1'b0;
        intr_pending = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("after_rst_flush", 32'(flush_from_wb), 32'd0);
            check("after_rst_ready", 32'(wb_ready), 32'd1);
        end
        intr_pending = 1'b0;

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            f = 6'b0;
            for (int b = 0; b < 6; b++) f[b] = ($urandom_range(0, 4) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? 32'hffff_fffc : ($urandom & 32'hffff_fffc);
            issue(f, rpc, $urandom, $urandom, $urandom, int'($urandom_range(0, 4)));
        end

`ifdef WB_FLUSH_PERF_CNT_EN
        check("perf_flush_cnt", perf_flush_cnt, 32'(n_flush));
        check("perf_mispred_cnt", perf_mispred_cnt, 32'(n_mispred));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_flush_gen.md
Name: wb_flush_gen

Overview:
Writeback-stage flush-request generator. It is the producing end of the pipeline flush protocol: it decides when the retiring instruction must flush the pipeline and raises `flush_from_wb` together with a redirect PC and a cause code. It also owns the multi-cycle waits that must complete before the flush can issue: the `ibar` cache drain and the `idle` wait for interrupt. It sits between the WB stage register and the hazard/flush distribution logic.

Parameters:
- PC_W, 32, width of all PC/target buses
- CAUSE_W, 3, width of the flush cause code
- CNT_W, 32, perf counter width (used only with the optional feature)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- wb_valid  in  1  WB holds a retiring instruction
- wb_ready  out  1  WB instruction accepted this cycle; WB stalls while 0
- wb_pc  in  PC_W  PC of WB instruction
- wb_excp  in  1  instruction raises an exception
- wb_ertn  in  1  instruction is `ertn`
- wb_br_mispred  in  1  branch mispredicted at resolution
- wb_br_target  in  PC_W  correct branch target
- wb_refetch  in  1  CSR/TLB/cacop op requiring refetch
- wb_ibar  in  1  instruction is `ibar`
- wb_idle  in  1  instruction is `idle`
- csr_eentry  in  PC_W  exception entry address
- csr_era  in  PC_W  exception return address
- intr_pending  in  1  unmasked interrupt pending
- dcache_idle  in  1  dcache and store buffer drained
- flush_from_wb  out  1  one-cycle flush request
- redirect_pc  out  PC_W  fetch restart PC, valid with `flush_from_wb`
- flush_cause  out  CAUSE_W  cause code, valid with `flush_from_wb`

Behaviour:
- FSM states: IDLE, FLUSH, DRAIN, HALT.
- `wb_ready` = (state==IDLE). Accept = `wb_valid & wb_ready`.
- Reset (async, any state):
  - state=IDLE, `flush_from_wb`=0, `redirect_pc`=0, `flush_cause`=0 (NONE); `wb_ready` is therefore 1.
  - A reset during DRAIN or HALT abandons the wait; no flush issues.
- Cause codes: NONE=0, EXCP=1, ERTN=2, MISPRED=3, REFETCH=4, IBAR=5, IDLE_WAKE=6.
- Priority when several flags are set on one accept: excp > ertn > mispred > ibar > idle > refetch. Lower-priority flags are ignored.
- Accept in IDLE with no flag set: no action, stay IDLE.
- Accept in IDLE with excp, ertn, mispred, or refetch: go to FLUSH, latching target and cause.
  - Targets: excp→`csr_eentry`; ertn→`csr_era`; mispred→`wb_br_target`; refetch→`wb_pc`+4.
- Accept with ibar: go to DRAIN; latch target `wb_pc`+4 and cause IBAR.
- Accept with idle: go to HALT; latch target `wb_pc`+4 and cause IDLE_WAKE.
- DRAIN: stay until `dcache_idle`=1, then go to FLUSH. If `dcache_idle` is already 1 in the first DRAIN cycle, exit on that cycle.
- HALT: stay until `intr_pending`=1, then go to FLUSH. The interrupt itself is taken later as `wb_excp` on a subsequent instruction.
- FLUSH:
  - `flush_from_wb`=1 for exactly one cycle, with registered `redirect_pc`/`flush_cause`.
  - Then return to IDLE.
  - Outside FLUSH, `flush_from_wb`=0 and `flush_cause`=NONE; `redirect_pc` holds its last value.
- Latency:
  - Accept→flush = 1 cycle for excp/ertn/mispred/refetch.
  - ibar: 1 cycle after `dcache_idle` is seen.
  - idle: 1 cycle after `intr_pending` is seen.
- PC arithmetic: `wb_pc`+4 is modulo 2^PC_W; it wraps silently.
- No new instruction is accepted from FLUSH through the return to IDLE. Upstream holds `wb_*` stable while `wb_ready`=0.

Optional Feature:
- Macro: `WB_FLUSH_PERF_CNT_EN`.
- Defined:
  - Adds outputs `perf_flush_cnt` [CNT_W] and `perf_mispred_cnt` [CNT_W].
  - Both are incremented on the FLUSH cycle: all causes, and MISPRED only, respectively.
  - They wrap at 2^CNT_W and reset to 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared header `flush_defs.vh` holds:
  - the cause-code defines (NONE..IDLE_WAKE);
  - the FSM state encodings;
  - the cause priority order, so the hazard unit decodes causes identically.
- One natural sub-module, `flush_perf_cnt`, is instantiated only under `WB_FLUSH_PERF_CNT_EN`.

Test Plan:
- Branch mispredict: accept `wb_br_mispred`=1, `wb_br_target`=0x1c000100 → next cycle `flush_from_wb`=1 for one cycle, `redirect_pc`=0x1c000100, cause=3; `wb_ready`=0 for exactly that cycle.
- Exception priority: accept `wb_excp`=1 and `wb_ertn`=1 together, `csr_eentry`=0x1c008000 → flush with `redirect_pc`=0x1c008000, cause=1.
- ibar drain: accept ibar at `wb_pc`=0x1c000200 with `dcache_idle`=0 for 5 cycles → `wb_ready`=0 throughout, no flush; `dcache_idle`=1 → flush next cycle with `redirect_pc`=0x1c000204, cause=5.
- idle wakeup: accept idle at 0x1c000300; `intr_pending` rises after 20 cycles → flush one cycle later with 0x1c000304, cause=6.
- Reset mid-wait: in HALT, assert `rst` → `flush_from_wb`=0 and `wb_ready`=1 immediately; no flush after release.
- PC wrap: refetch at `wb_pc`=0xfffffffc → `redirect_pc`=0x00000000. With the macro defined, 3 flushes (1 mispred) → `perf_flush_cnt`=3, `perf_mispred_cnt`=1.
